tlb_assoc_store: RTL
====================

# tlb_assoc_store

Parametrised set-associative TLB array. It performs the tag lookup internally and returns a registered hit/miss response, and it selects a replacement victim on every lookup. It also keeps saturating LRU counters with set-wide aging and provides a multi-cycle flush sequencer. It sits between the translation control FSM and the page-walk fill path and replaces the fixed 20-bit, externally-compared storage array.

## Interface
- `NUM_SETS`, 16: number of sets; power of two, ≥2. `SET_BITS = $clog2(NUM_SETS)`.
- `NUM_WAYS`, 4: associativity; power of two, ≥2. `WAY_BITS = $clog2(NUM_WAYS)`.
- `VPN_W`, 20: virtual page number width.
- `PPN_W`, 20: physical page number width.
- `PERM_W`, 2: permission field width.
- `LRU_BITS`, 4: per-entry usage counter width. `LRU_MAX = 2^LRU_BITS-1`.
- `ASID_W`, 8: address-space ID width.

Ports:
- `clk`  in  1  clock. One clock domain.
- `rst`  in  1  reset; asynchronous, active-high. Clears every entry and every output.
- `lk_valid`  in  1  lookup request.
- `lk_ready`  out  1  low while a flush is in progress.
- `lk_vpn`  in  VPN_W  lookup VPN; set index = `lk_vpn[SET_BITS-1:0]`.
- `lk_asid`  in  ASID_W  lookup ASID.
- `rsp_valid`  out  1  one-cycle pulse, one cycle after an accepted lookup.
- `rsp_hit`  out  1  the lookup matched an entry.
- `rsp_way`  out  WAY_BITS  way that hit.
- `rsp_ppn`  out  PPN_W  PPN of the hit entry; 0 on miss.
- `rsp_perms`  out  PERM_W  permissions of the hit entry; 0 on miss.
- `rsp_victim`  out  WAY_BITS  replacement way for the looked-up set.
- `wr_en`  in  1  fill write.
- `wr_way`  in  WAY_BITS  target way.
- `wr_vpn`  in  VPN_W  tag; set index is taken from its low bits.
- `wr_asid`  in  ASID_W  ASID to store.
- `wr_ppn`  in  PPN_W  PPN to store.
- `wr_perms`  in  PERM_W  permissions to store.
- `flush_req`  in  1  start a full invalidate.
- `flush_busy`  out  1  flush sequencer active.
- `flush_done`  out  1  one-cycle pulse when the flush completes.

## Operation
- Entry contents: valid, full VPN tag, ASID (macro-dependent), PPN, perms, LRU count.
- **Lookup** is accepted when `lk_valid && lk_ready`. Hit condition: `valid && tag==lk_vpn`, plus the ASID match when enabled. If more than one way matches, the lowest way index is reported.
- **Victim selection**: the lowest-index invalid way; if no way is invalid, the way with the minimum LRU count, ties going to the lowest index. Computed from pre-update state.
- **Hit LRU update**:
  - If the hit way's count < `LRU_MAX`, it increments by 1.
  - If it is at `LRU_MAX` (aging), every count in the set shifts right by 1 and the hit way becomes `(LRU_MAX>>1)+1`.
  - Misses leave LRU state unchanged.
- **Write** (when `wr_en && !flush_busy`): sets valid=1 and stores tag/ASID/PPN/perms at (set, `wr_way`). The LRU count becomes 1. Other ways are untouched. `wr_en` during a flush is dropped.
- **Same-cycle write and lookup**: the lookup sees pre-write contents (read-before-write). If the hit LRU update and the write target the same entry, the write wins.
- **Flush FSM**, states IDLE and SWEEP:
  - IDLE→SWEEP on `flush_req`, and the set pointer is cleared to 0.
  - Each SWEEP cycle clears valid and LRU for every way of the pointed set, then increments the pointer.
  - After set `NUM_SETS-1`, SWEEP→IDLE and `flush_done` pulses on that same cycle.
  - `flush_req` while in SWEEP is ignored.
- **Reset mid-flush** aborts the flush to IDLE with all entries cleared, and no `flush_done` is issued.

## Timing
- Lookup latency is 1 cycle. `rsp_*` are registered and hold their values until the next accepted lookup; only `rsp_valid` pulses.
- Writes take effect at the clock edge. A lookup in the following cycle observes the written entry.
- A flush takes exactly `NUM_SETS` cycles with `flush_busy=1`. `lk_ready = !flush_busy`, combinational from state. `flush_req` is sampled in IDLE; the first cleared set is on the next edge.
- Reset values: `lk_ready=1`; `rsp_valid`, `rsp_hit`, `rsp_way`, `rsp_ppn`, `rsp_perms`, `rsp_victim`, `flush_busy`, `flush_done` all 0; every entry invalid with LRU 0.

## Configuration
- `TLB_ASID_EN` defined: each entry stores `ASID_W` bits, and a hit additionally requires `stored_asid==lk_asid`.
- `TLB_ASID_EN` undefined: no ASID storage, and the hit is on VPN only. `lk_asid` and `wr_asid` remain as ports but are ignored.

## Test plan
- **Reset then lookup**: reset, then lookup VPN 0x00013 → `rsp_valid` one cycle later with hit=0, victim=0, ppn=0.
- **Fill and hit**: write set 3 way 2 with VPN 0x00013→PPN 0xABCDE, perms 2'b11; next-cycle lookup 0x00013 → hit=1, way=2, ppn=0xABCDE, perms=3; that entry's LRU=2.
- **Victim choice**: fill all 4 ways of set 3, then hit ways 0, 1 and 3 once each → next lookup to set 3 reports victim=2.
- **Aging**: with `LRU_BITS=4`, hit one entry until its count reaches 15; the next hit sets the set's counts to 8 for the hit way and old>>1 for the others.
- **Flush**: pulse `flush_req` with the default 16 sets → `flush_busy` high for 16 cycles, `lk_ready` low for those cycles, `flush_done` pulses once, a `wr_en` issued mid-flush is dropped, and all subsequent lookups miss. Assert `rst` mid-flush → outputs return to reset values and no `flush_done` is seen.
- **ASID**: with `TLB_ASID_EN`, fill with ASID 5 and look up with ASID 6 → miss; without the macro, the same lookup → hit.

Source files
------------

// File: rtl/tlb_assoc_store.sv
// Set-associative TLB array: internal tag compare, registered hit/miss response,
// victim selection, saturating LRU counters with set-wide aging, and a flush sequencer.
// Optional macro TLB_ASID_EN adds per-entry ASID storage and ASID match on lookup.
module tlb_assoc_store #(
  parameter int NUM_SETS = 16,
  parameter int NUM_WAYS = 4,
  parameter int VPN_W    = 20,
  parameter int PPN_W    = 20,
  parameter int PERM_W   = 2,
  parameter int LRU_BITS = 4,
  parameter int ASID_W   = 8,
  localparam int SET_BITS = $clog2(NUM_SETS),
  localparam int WAY_BITS = $clog2(NUM_WAYS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                lk_valid,
  output logic                lk_ready,
  input  logic [VPN_W-1:0]    lk_vpn,
  input  logic [ASID_W-1:0]   lk_asid,
  output logic                rsp_valid,
  output logic                rsp_hit,
  output logic [WAY_BITS-1:0] rsp_way,
  output logic [PPN_W-1:0]    rsp_ppn,
  output logic [PERM_W-1:0]   rsp_perms,
  output logic [WAY_BITS-1:0] rsp_victim,
  input  logic                wr_en,
  input  logic [WAY_BITS-1:0] wr_way,
  input  logic [VPN_W-1:0]    wr_vpn,
  input  logic [ASID_W-1:0]   wr_asid,
  input  logic [PPN_W-1:0]    wr_ppn,
  input  logic [PERM_W-1:0]   wr_perms,
  input  logic                flush_req,
  output logic                flush_busy,
  output logic                flush_done
);

  localparam logic [LRU_BITS-1:0] LRU_MAX  = '1;
  localparam logic [LRU_BITS-1:0] LRU_AGED = (LRU_MAX >> 1) + 1'b1;
  localparam logic [SET_BITS-1:0] LAST_SET = SET_BITS'(NUM_SETS - 1);

  typedef enum logic {IDLE, SWEEP} flush_state_e;

  flush_state_e                 state_q, state_d;
  logic [SET_BITS-1:0]          ptr_q, ptr_d;

  logic [NUM_SETS-1:0][NUM_WAYS-1:0]               valid_q, valid_d;
  logic [NUM_SETS-1:0][NUM_WAYS-1:0][VPN_W-1:0]    tag_q, tag_d;
  logic [NUM_SETS-1:0][NUM_WAYS-1:0][PPN_W-1:0]    ppn_q, ppn_d;
  logic [NUM_SETS-1:0][NUM_WAYS-1:0][PERM_W-1:0]   perms_q, perms_d;
  logic [NUM_SETS-1:0][NUM_WAYS-1:0][LRU_BITS-1:0] lru_q, lru_d;
`ifdef TLB_ASID_EN
  logic [NUM_SETS-1:0][NUM_WAYS-1:0][ASID_W-1:0]   asid_q, asid_d;
`else
  logic unused_asid;
  assign unused_asid = ^{lk_asid, wr_asid};
`endif

  logic                rsp_valid_q, rsp_valid_d;
  logic                rsp_hit_q, rsp_hit_d;
  logic [WAY_BITS-1:0] rsp_way_q, rsp_way_d;
  logic [PPN_W-1:0]    rsp_ppn_q, rsp_ppn_d;
  logic [PERM_W-1:0]   rsp_perms_q, rsp_perms_d;
  logic [WAY_BITS-1:0] rsp_victim_q, rsp_victim_d;

  logic [SET_BITS-1:0] lk_set, wr_set;
  logic                lk_fire, wr_fire;
  logic                hit;
  logic [WAY_BITS-1:0] hit_way, victim_way, free_way, lru_way;
  logic                have_free;
  logic [LRU_BITS-1:0] min_lru;

  assign flush_busy = (state_q == SWEEP);
  assign lk_ready   = ~flush_busy;
  assign flush_done = flush_busy && (ptr_q == LAST_SET);
  assign lk_set     = lk_vpn[SET_BITS-1:0];
  assign wr_set     = wr_vpn[SET_BITS-1:0];
  assign lk_fire    = lk_valid && lk_ready;
  assign wr_fire    = wr_en && !flush_busy;

  // Tag match and victim choice; descending scans let the lowest index win.
  always_comb begin
    hit       = 1'b0;
    hit_way   = '0;
    have_free = 1'b0;
    free_way  = '0;
    for (int w = NUM_WAYS - 1; w >= 0; w--) begin
      if (valid_q[lk_set][w] && (tag_q[lk_set][w] == lk_vpn)
`ifdef TLB_ASID_EN
          && (asid_q[lk_set][w] == lk_asid)
`endif
         ) begin
        hit     = 1'b1;
        hit_way = WAY_BITS'(w);
      end
      if (!valid_q[lk_set][w]) begin
        have_free = 1'b1;
        free_way  = WAY_BITS'(w);
      end
    end
    min_lru = lru_q[lk_set][0];
    lru_way = '0;
    for (int w = 1; w < NUM_WAYS; w++) begin
      if (lru_q[lk_set][w] < min_lru) begin
        min_lru = lru_q[lk_set][w];
        lru_way = WAY_BITS'(w);
      end
    end
    victim_way = have_free ? free_way : lru_way;
  end

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    valid_d = valid_q;
    tag_d   = tag_q;
    ppn_d   = ppn_q;
    perms_d = perms_q;
    lru_d   = lru_q;
`ifdef TLB_ASID_EN
    asid_d  = asid_q;
`endif

    if (lk_fire && hit) begin
      if (lru_q[lk_set][hit_way] != LRU_MAX) begin
        lru_d[lk_set][hit_way] = lru_q[lk_set][hit_way] + 1'b1;
      end else begin
        for (int w = 0; w < NUM_WAYS; w++) lru_d[lk_set][w] = lru_q[lk_set][w] >> 1;
        lru_d[lk_set][hit_way] = LRU_AGED;
      end
    end

    // Applied after the LRU update so a fill to the same entry wins.
    if (wr_fire) begin
      valid_d[wr_set][wr_way] = 1'b1;
      tag_d[wr_set][wr_way]   = wr_vpn;
      ppn_d[wr_set][wr_way]   = wr_ppn;
      perms_d[wr_set][wr_way] = wr_perms;
      lru_d[wr_set][wr_way]   = LRU_BITS'(1);
`ifdef TLB_ASID_EN
      asid_d[wr_set][wr_way]  = wr_asid;
`endif
    end

    unique case (state_q)
      IDLE: begin
        if (flush_req) begin
          state_d = SWEEP;
          ptr_d   = '0;
        end
      end
      SWEEP: begin
        valid_d[ptr_q] = '0;
        lru_d[ptr_q]   = '0;
        ptr_d          = ptr_q + 1'b1;
        if (ptr_q == LAST_SET) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    rsp_valid_d  = lk_fire;
    rsp_hit_d    = rsp_hit_q;
    rsp_way_d    = rsp_way_q;
    rsp_ppn_d    = rsp_ppn_q;
    rsp_perms_d  = rsp_perms_q;
    rsp_victim_d = rsp_victim_q;
    if (lk_fire) begin
      rsp_hit_d    = hit;
      rsp_way_d    = hit ? hit_way : '0;
      rsp_ppn_d    = hit ? ppn_q[lk_set][hit_way] : '0;
      rsp_perms_d  = hit ? perms_q[lk_set][hit_way] : '0;
      rsp_victim_d = victim_way;
    end
  end

  // NOTE: the whole array is reset because reset must leave every entry invalid with LRU 0;
  // clearing only valid/LRU would suffice functionally but full reset keeps X out of the outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      ptr_q        <= '0;
      valid_q      <= '0;
      tag_q        <= '0;
      ppn_q        <= '0;
      perms_q      <= '0;
      lru_q        <= '0;
`ifdef TLB_ASID_EN
      asid_q       <= '0;
`endif
      rsp_valid_q  <= 1'b0;
      rsp_hit_q    <= 1'b0;
      rsp_way_q    <= '0;
      rsp_ppn_q    <= '0;
      rsp_perms_q  <= '0;
      rsp_victim_q <= '0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      valid_q      <= valid_d;
      tag_q        <= tag_d;
      ppn_q        <= ppn_d;
      perms_q      <= perms_d;
      lru_q        <= lru_d;
`ifdef TLB_ASID_EN
      asid_q       <= asid_d;
`endif
      rsp_valid_q  <= rsp_valid_d;
      rsp_hit_q    <= rsp_hit_d;
      rsp_way_q    <= rsp_way_d;
      rsp_ppn_q    <= rsp_ppn_d;
      rsp_perms_q  <= rsp_perms_d;
      rsp_victim_q <= rsp_victim_d;
    end
  end

  assign rsp_valid  = rsp_valid_q;
  assign rsp_hit    = rsp_hit_q;
  assign rsp_way    = rsp_way_q;
  assign rsp_ppn    = rsp_ppn_q;
  assign rsp_perms  = rsp_perms_q;
  assign rsp_victim = rsp_victim_q;

endmodule
